mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single unified Memory_0 instance in the datapath between the instruction-fetch path and the load/store data path. Each side runs a req/ack handshake; the arbiter issues one memory transaction at a time and waits a fixed memory latency. It returns the read data to the owning requester. It sits inside DataPath_0, between the fetch and memory-stage logic and the memory array.

Parameters:
ADDR_W, 32, byte address width on all address ports.
DATA_W, 32, data word width.
MEM_LATENCY, 2, cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
if_req  in  1  fetch read request; held until if_ack.
if_addr  in  ADDR_W  fetch address.
if_ack  out  1  one-cycle completion pulse to fetch.
if_rdata  out  DATA_W  fetched word; valid while if_ack=1.
d_req  in  1  data request; held until d_ack.
d_we  in  1  1 = store, 0 = load.
d_addr  in  ADDR_W  data address.
d_wdata  in  DATA_W  store data.
d_ack  out  1  one-cycle completion pulse to data side.
d_rdata  out  DATA_W  load data while d_ack=1; 0 for a store ack.
mem_en  out  1  one-cycle issue strobe to memory.
mem_we  out  1  write enable; qualified by mem_en.
mem_addr  out  ADDR_W  registered address; held from issue until the next issue.
mem_wdata  out  DATA_W  registered write data; held like mem_addr.
mem_rdata  in  DATA_W  memory read data; valid MEM_LATENCY cycles after mem_en.
busy  out  1  1 whenever state != IDLE.
owner  out  1  current or last grant: 0 = fetch, 1 = data.

Behaviour:
- Reset (reset=0, asynchronous):
  - state = IDLE; latency counter = 0; last_grant = 0.
  - All outputs are 0.
  - Any in-flight transaction is dropped and never acked.
- State machine:
  - IDLE: sample if_req and d_req.
    - If either is high, choose a winner (priority rule below).
    - At the clock edge, latch its addr, we and wdata into mem_addr, mem_we and mem_wdata; set owner; go to WAIT.
    - mem_en=1 is registered and high for exactly the first WAIT cycle.
  - WAIT: the counter loads MEM_LATENCY at issue and decrements each cycle.
    - In the cycle the counter equals 0, mem_rdata is captured; go to RESP.
  - RESP: ack of the owner = 1 for exactly this cycle.
    - rdata = captured word for a load, 0 for a store.
    - The other ack stays 0. Requests are ignored. Next state is IDLE.
- Latency: a request first high in IDLE cycle R gives:
  - mem_en in cycle R+1;
  - mem_rdata valid in cycle R+1+MEM_LATENCY;
  - ack in cycle R+2+MEM_LATENCY.
  - Peak throughput is one transaction per MEM_LATENCY+3 cycles.
- Priority (default): data beats fetch on a simultaneous request.
- Requester rules:
  - Inputs are latched at grant, so changes after grant are ignored.
  - A requester must drop or replace req in the cycle after its ack.
  - A req dropped before ack does not cancel the transaction; the ack still pulses.
  - A req held high across RESP is re-arbitrated in the following IDLE cycle as a new transaction.
- Both acks are never high in the same cycle. mem_en is never high outside the first WAIT cycle.
- mem_en goes low combinationally-free: it is a register output and is cleared on the cycle after issue.

Optional Feature:
MEMARB_ROUND_ROBIN_EN
- Defined:
  - On a simultaneous request in IDLE, the port not named by last_grant wins.
  - last_grant updates to the winner at every grant; reset value is 0, so the first tie goes to data.
  - A single requester is always granted regardless of last_grant.
- Undefined:
  - Fixed priority, data over fetch; last_grant is unused.
  - Continuous d_req may starve fetch by design.

Test Plan:
- Reset then fetch read, MEM_LATENCY=2, memory word 0x20100009 at addr 0x4: if_req=1 in cycle R -> mem_en=1, mem_addr=0x4 in R+1; if_ack=1, if_rdata=0x20100009 in R+4; busy=1 for R+1..R+4.
- Store: d_req=1, d_we=1, d_addr=0x10, d_wdata=0xDEADBEEF -> one mem_en with mem_we=1 carrying those values; d_ack in R+4 with d_rdata=0; a following load of 0x10 returns 0xDEADBEEF.
- Simultaneous if_req and d_req held high (fixed priority) -> data granted first (owner=1); fetch granted in the IDLE cycle after d_ack; the acks are 5 cycles apart.
- With MEMARB_ROUND_ROBIN_EN, both requests held high for 4 transactions -> grant order data, fetch, data, fetch.
- Reset asserted in the second WAIT cycle -> all outputs 0 immediately; no ack; a fresh if_req after reset release completes normally.
- d_req dropped one cycle after grant -> d_ack still pulses once; no second mem_en issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets the fetch path and the load/store path share one
// unified memory. It issues one transaction at a time, waits a fixed read
// latency, then acks the requester that owns the transaction.
// Optional build macro MEMARB_ROUND_ROBIN_EN: when it is defined, a tie
// goes to the port that did not win the last grant. When it is undefined,
// data always beats fetch.
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant_data;

    // Pick the winner for the IDLE cycle. owner_q also holds the last grant.
    // Fetch (0) is the reset value, so the first tie goes to data.
    always_comb begin
`ifdef MEMARB_ROUND_ROBIN_EN
        grant_data = d_req && (!if_req || !owner_q);
`else
        grant_data = d_req;
`endif
    end

    // Next-state logic: issue in IDLE, count latency in WAIT, ack in RESP.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    state_d     = ST_WAIT;
                    mem_en_d    = 1'b1;
                    cnt_d       = 4'(MEM_LATENCY);
                    owner_d     = grant_data;
                    mem_we_d    = grant_data ? d_we : 1'b0;
                    mem_addr_d  = grant_data ? d_addr : if_addr;
                    mem_wdata_d = grant_data ? d_wdata : '0;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = mem_rdata;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset drops any in-flight transaction.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    // Output decode. Acks and read data come from registered state only.
    always_comb begin
        if_ack    = (state_q == ST_RESP) && !owner_q;
        d_ack     = (state_q == ST_RESP) && owner_q;
        if_rdata  = if_ack ? rdata_q : '0;
        d_rdata   = (d_ack && !mem_we_q) ? rdata_q : '0;
        mem_en    = mem_en_q;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        busy      = (state_q != ST_IDLE);
        owner     = owner_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. A scoreboard
// queue holds the expected ack port and data for each transaction, and a
// monitor compares them on every ack.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LAT    = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              d_req = 1'b0;
    logic              d_we = 1'b0;
    logic [ADDR_W-1:0] d_addr = '0;
    logic [DATA_W-1:0] d_wdata = '0;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;
    logic              owner;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(LAT)) dut (
        .clock(clock), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Memory model: data is valid exactly LAT cycles after mem_en; garbage otherwise.
    logic [31:0] mem [0:15];
    logic [31:0] rd_q = '0;
    int          lat_q = 0;
    always @(posedge clock) begin
        if (!reset) begin
            mem[1] <= 32'h20100009;
            lat_q  <= 0;
        end else begin
            if (mem_en && mem_we) mem[mem_addr[5:2]] <= mem_wdata;
            if (mem_en) begin
                lat_q <= LAT;
                rd_q  <= mem[mem_addr[5:2]];
            end else if (lat_q != 0) begin
                lat_q <= lat_q - 1;
            end
        end
    end
    assign mem_rdata = (lat_q == 1) ? rd_q : 32'hBAD0BAD0;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void check_output(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct {
        logic        port;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    function automatic void push_exp(logic port, logic [31:0] data);
        exp_t e;
        e.port = port;
        e.data = data;
        sb.push_back(e);
    endfunction

    int          mem_en_cnt = 0;
    int          if_ack_cnt = 0;
    int          d_ack_cnt  = 0;
    logic        grant_log[$];
    logic        last_we;
    logic [31:0] last_addr;
    logic [31:0] last_wdata;

    // Monitor: log issues and compare every ack against the scoreboard.
    always @(negedge clock) begin
        if (reset) begin
            if (mem_en) begin
                mem_en_cnt++;
                grant_log.push_back(owner);
                last_we    = mem_we;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
            end
            if (if_ack || d_ack) begin
                if (if_ack) if_ack_cnt++;
                if (d_ack) d_ack_cnt++;
                check_output("ack_exclusive", {63'd0, if_ack & d_ack}, 64'd0);
                check_output("ack_expected", {63'd0, sb.size() != 0}, 64'd1);
                if (sb.size() != 0) begin
                    mon_e = sb.pop_front();
                    check_output("ack_port", {63'd0, d_ack}, {63'd0, mon_e.port});
                    check_output("ack_rdata", {32'd0, d_ack ? d_rdata : if_rdata}, {32'd0, mon_e.data});
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ack(input logic port, output int ack_cyc);
        ack_cyc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clock);
            if (port ? d_ack : if_ack) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL ack_timeout: port %0d never acked", port);
        end
    endtask

    // One complete transaction on one port; req is dropped the cycle after ack.
    task automatic apply_stimulus(input logic port, input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] exp_data,
                                  output int latency);
        int r;
        int a;
        r = cyc;
        push_exp(port, exp_data);
        if (port) begin
            d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        wait_ack(port, a);
        next_cycle();
        if_req = 1'b0;
        d_req  = 1'b0;
        latency = a - r;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r, a1, a2, lat, g0, c0, c1;
        logic [3:0] order;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check_output("rst_acks", {62'd0, if_ack, d_ack}, 64'd0);
        check_output("rst_ctrl", {60'd0, mem_en, mem_we, busy, owner}, 64'd0);
        check_output("rst_addr", {32'd0, mem_addr}, 64'd0);
        check_output("rst_data", {if_rdata, d_rdata}, 64'd0);
        reset = 1'b1;
        next_cycle();

        // Fetch read with cycle-exact timing
        r = cyc;
        push_exp(1'b0, 32'h20100009);
        if_addr = 32'h4;
        if_req  = 1'b1;
        @(negedge clock);
        check_output("f_busy_R", {63'd0, busy}, 64'd0);
        @(negedge clock);
        check_output("f_en_R1", {62'd0, mem_en, mem_we}, 64'd2);
        check_output("f_addr_R1", {32'd0, mem_addr}, 64'h4);
        check_output("f_busy_R1", {62'd0, busy, owner}, 64'd2);
        @(negedge clock);
        check_output("f_en_R2", {62'd0, mem_en, busy}, 64'd1);
        @(negedge clock);
        check_output("f_ack_R3", {61'd0, if_ack, d_ack, busy}, 64'd1);
        @(negedge clock);
        check_output("f_ack_R4", {61'd0, if_ack, d_ack, busy}, 64'd5);
        check_output("f_ack_cycle", 64'(cyc - r), 64'd4);
        next_cycle();
        if_req = 1'b0;
        @(negedge clock);
        check_output("f_busy_R5", {63'd0, busy}, 64'd0);
        next_cycle();

        // Store then load back
        c0 = mem_en_cnt;
        apply_stimulus(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, lat);
        check_output("st_latency", 64'(lat), 64'(LAT + 2));
        check_output("st_issues", 64'(mem_en_cnt - c0), 64'd1);
        check_output("st_mem_we", {63'd0, last_we}, 64'd1);
        check_output("st_mem_addr", {32'd0, last_addr}, 64'h10);
        check_output("st_mem_wdata", {32'd0, last_wdata}, 64'hDEADBEEF);
        apply_stimulus(1'b1, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, lat);
        check_output("ld_latency", 64'(lat), 64'(LAT + 2));

`ifndef MEMARB_ROUND_ROBIN_EN
        // Simultaneous request: data first, fetch in the IDLE cycle after d_ack
        g0 = grant_log.size();
        push_exp(1'b1, 32'hDEADBEEF);
        push_exp(1'b0, 32'h20100009);
        if_addr = 32'h4; if_req = 1'b1;
        d_addr = 32'h10; d_we = 1'b0; d_req = 1'b1;
        wait_ack(1'b1, a1);
        next_cycle();
        d_req = 1'b0;
        wait_ack(1'b0, a2);
        next_cycle();
        if_req = 1'b0;
        check_output("tie_ack_gap", 64'(a2 - a1), 64'd5);
        check_output("tie_grants", 64'(grant_log.size() - g0), 64'd2);
        if (grant_log.size() >= g0 + 2)
            check_output("tie_order", {62'd0, grant_log[g0], grant_log[g0 + 1]}, 64'd2);
`endif

        // Both held for four transactions after a fresh reset
        reset = 1'b0;
        next_cycle();
        reset = 1'b1;
        next_cycle();
        g0 = grant_log.size();
`ifdef MEMARB_ROUND_ROBIN_EN
        order = 4'b1010;
`else
        order = 4'b1111;
`endif
        for (int k = 3; k >= 0; k--)
            push_exp(order[k], order[k] ? 32'hDEADBEEF : 32'h20100009);
        if_addr = 32'h4; if_req = 1'b1;
        d_addr = 32'h10; d_we = 1'b0; d_req = 1'b1;
        c1 = if_ack_cnt + d_ack_cnt;
        for (int n = 0; n < 100 && (if_ack_cnt + d_ack_cnt - c1) < 4; n++)
            @(negedge clock);
        next_cycle();
        if_req = 1'b0;
        d_req  = 1'b0;
        check_output("hold_acks", 64'(if_ack_cnt + d_ack_cnt - c1), 64'd4);
        if (grant_log.size() >= g0 + 4)
            check_output("hold_order",
                         {60'd0, grant_log[g0], grant_log[g0 + 1], grant_log[g0 + 2], grant_log[g0 + 3]},
                         {60'd0, order});
        next_cycle();

        // Reset in the second WAIT cycle
        c1 = if_ack_cnt;
        if_addr = 32'h4;
        if_req  = 1'b1;
        next_cycle();
        next_cycle();
        reset  = 1'b0;
        if_req = 1'b0;
        #1;
        check_output("mid_rst_ctrl", {58'd0, mem_en, mem_we, busy, owner, if_ack, d_ack}, 64'd0);
        check_output("mid_rst_addr", {32'd0, mem_addr}, 64'd0);
        repeat (3) next_cycle();
        reset = 1'b1;
        repeat (6) next_cycle();
        check_output("mid_rst_no_ack", 64'(if_ack_cnt - c1), 64'd0);
        apply_stimulus(1'b0, 1'b0, 32'h4, 32'h0, 32'h20100009, lat);
        check_output("post_rst_latency", 64'(lat), 64'(LAT + 2));

        // d_req dropped one cycle after grant
        c0 = mem_en_cnt;
        c1 = d_ack_cnt;
        push_exp(1'b1, 32'hDEADBEEF);
        d_addr = 32'h10; d_we = 1'b0; d_req = 1'b1;
        next_cycle();
        d_req = 1'b0;
        wait_ack(1'b1, a1);
        repeat (4) next_cycle();
        check_output("drop_issues", 64'(mem_en_cnt - c0), 64'd1);
        check_output("drop_acks", 64'(d_ack_cnt - c1), 64'd1);

        check_output("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
